// File: rtl/carry_resolver_if.sv
// rtl/carry_resolver_if.sv - byte stream handshake bundle between encoder, resolver and sink
interface carry_resolver_if;
   logic       in_valid;
   logic [8:0] in_data;
   logic       in_ready;
   logic       flush;
   logic       out_valid;
   logic [7:0] out_byte;
   logic       out_ready;
   logic       flush_done;
   logic       err;

   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_byte, flush_done, err
   );

   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_byte, flush_done, err
   );
endinterface

// File: rtl/carry_resolver.sv
// rtl/carry_resolver.sv - resolves late carries from the arithmetic encoder by holding one byte
// plus a count of pending 0xFF bytes until the carry into them is known.
module carry_resolver #(
   parameter int RUN_CNT_WIDTH = 16
) (
   input  logic             general_clk,
   input  logic             reset,
   carry_resolver_if.slave  bus
);

   localparam logic [1:0] ACCEPT    = 2'd0;
   localparam logic [1:0] EMIT_HELD = 2'd1;
   localparam logic [1:0] EMIT_RUN  = 2'd2;
   localparam logic [1:0] FLUSH_END = 2'd3;

   localparam logic [RUN_CNT_WIDTH-1:0] CNT_ONE = RUN_CNT_WIDTH'(1);

   logic [1:0]               r_state;
   logic                     r_armed;
   logic                     r_held_valid;
   logic [7:0]               r_held_byte;
   logic [RUN_CNT_WIDTH-1:0] r_ff_cnt;
   logic [7:0]               r_emit_val;
   logic [7:0]               r_run_val;
   logic [RUN_CNT_WIDTH-1:0] r_run_len;
   logic                     r_flushing;
   logic                     r_err;

   logic       w_in_ready;
   logic       w_in_fire;
   logic       w_flush_req;
   logic       w_carry;
   logic [7:0] w_byte;
   logic       w_ff_max;
   logic [7:0] w_held_inc;
   logic [1:0] w_after_emit;
   logic [7:0] w_out_byte;

   // r_armed keeps in_ready low until the first edge after reset release
   assign w_in_ready   = (r_state == ACCEPT) && r_armed;
   assign w_in_fire    = bus.in_valid && w_in_ready;
   assign w_flush_req  = w_in_ready && !bus.in_valid && bus.flush;
   assign w_carry      = bus.in_data[8];
   assign w_byte       = bus.in_data[7:0];
   assign w_ff_max     = &r_ff_cnt;
   assign w_held_inc   = r_held_byte + 8'd1;
   assign w_after_emit = r_flushing ? FLUSH_END : ACCEPT;

   always_comb begin
      w_out_byte = 8'h00;
      case (r_state)
         EMIT_HELD: w_out_byte = r_emit_val;
         EMIT_RUN:  w_out_byte = r_run_val;
         default:   w_out_byte = 8'h00;
      endcase
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = (r_state == EMIT_HELD) || (r_state == EMIT_RUN);
   assign bus.out_byte   = w_out_byte;
   assign bus.flush_done = (r_state == FLUSH_END);
   assign bus.err        = r_err;

   always_ff @(posedge general_clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ACCEPT;
         r_armed      <= 1'b0;
         r_held_valid <= 1'b0;
         r_held_byte  <= 8'h00;
         r_ff_cnt     <= '0;
         r_emit_val   <= 8'h00;
         r_run_val    <= 8'h00;
         r_run_len    <= '0;
         r_flushing   <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         case (r_state)
            ACCEPT: begin
               if (w_in_fire) begin
                  if (!r_held_valid) begin
                     // nothing to carry into yet: the carry is lost
                     r_held_byte  <= w_byte;
                     r_held_valid <= 1'b1;
                     if (w_carry) begin
                        r_err <= 1'b1;
                     end
                  end else if (!w_carry && (w_byte == 8'hFF)) begin
                     if (w_ff_max) begin
                        r_err <= 1'b1;
                     end else begin
                        r_ff_cnt <= r_ff_cnt + CNT_ONE;
                     end
                  end else begin
                     r_emit_val  <= w_carry ? w_held_inc : r_held_byte;
                     r_run_val   <= w_carry ? 8'h00 : 8'hFF;
                     r_run_len   <= r_ff_cnt;
                     r_held_byte <= w_byte;
                     r_ff_cnt    <= '0;
                     r_flushing  <= 1'b0;
                     r_state     <= EMIT_HELD;
                     if (w_carry && (r_held_byte == 8'hFF)) begin
                        r_err <= 1'b1;
                     end
                  end
               end else if (w_flush_req) begin
                  if (r_held_valid) begin
                     r_emit_val   <= r_held_byte;
                     r_run_val    <= 8'hFF;
                     r_run_len    <= r_ff_cnt;
                     r_held_valid <= 1'b0;
                     r_ff_cnt     <= '0;
                     r_flushing   <= 1'b1;
                     r_state      <= EMIT_HELD;
                  end else begin
                     r_state <= FLUSH_END;
                  end
               end
            end

            EMIT_HELD: begin
               if (bus.out_ready) begin
                  r_state <= (r_run_len != '0) ? EMIT_RUN : w_after_emit;
               end
            end

            EMIT_RUN: begin
               if (bus.out_ready) begin
                  r_run_len <= r_run_len - CNT_ONE;
                  if (r_run_len == CNT_ONE) begin
                     r_state <= w_after_emit;
                  end
               end
            end

            default: begin
               r_flushing <= 1'b0;
               r_state    <= ACCEPT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_carry_resolver.sv
// tb/tb_carry_resolver.sv - directed-vector bench for carry_resolver
module tb_carry_resolver;

   logic general_clk;
   logic reset;
   int   errors;
   int   checks;
   int   fd_cnt;
   logic [7:0] q[$];

   carry_resolver_if bus ();

   carry_resolver #(.RUN_CNT_WIDTH(16)) dut (
      .general_clk (general_clk),
      .reset       (reset),
      .bus         (bus)
   );

   initial general_clk = 1'b0;
   always #5 general_clk = ~general_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   // all driving and observing happens at the falling edge
   task automatic observe();
      if (bus.out_valid && bus.out_ready) q.push_back(bus.out_byte);
      if (bus.flush_done) fd_cnt++;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) begin
         bus.in_valid  = 1'b0;
         bus.flush     = 1'b0;
         bus.out_ready = rdy;
         observe();
         @(negedge general_clk);
      end
   endtask

   task automatic send(input logic [8:0] d, input logic rdy);
      logic done;
      int   n;
      done = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         bus.in_valid  = 1'b1;
         bus.in_data   = d;
         bus.flush     = 1'b0;
         bus.out_ready = rdy;
         done = bus.in_ready;
         observe();
         @(negedge general_clk);
         n++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_timeout data=%03h got in_ready=0 want 1", d);
      end
   endtask

   task automatic do_flush();
      int n;
      int fd0;
      n = 0;
      while (!bus.in_ready && n < 30) begin
         idle(1, 1'b1);
         n++;
      end
      fd0 = fd_cnt;
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      observe();
      @(negedge general_clk);
      bus.flush = 1'b0;
      n = 0;
      while (fd_cnt == fd0 && n < 30) begin
         idle(1, 1'b1);
         n++;
      end
      checks++;
      if (fd_cnt == fd0) begin
         errors++;
         $display("FAIL flush_timeout got flush_done=0 want 1");
      end
   endtask

   task automatic apply_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = 9'h000;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      reset = 1'b0;
      @(negedge general_clk);
      @(negedge general_clk);
      reset = 1'b1;
      @(negedge general_clk);
      q.delete();
      fd_cnt = 0;
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = 9'h000;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      reset = 1'b0;
      @(negedge general_clk);
      @(negedge general_clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      checks++;
      if (bus.out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte got %02h want 00", bus.out_byte); end
      checks++;
      if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b want 0", bus.flush_done); end
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
      reset = 1'b1;
      @(negedge general_clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready); end
      q.delete();
      fd_cnt = 0;
   endtask

   task automatic test_basic();
      logic [7:0] exp[$];
      exp = '{8'h12, 8'h34};
      apply_reset();
      send(9'h012, 1'b1);
      send(9'h034, 1'b1);
      idle(3, 1'b1);
      do_flush();
      checks++;
      if (q.size() != exp.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (i >= q.size() || q[i] !== exp[i]) begin
            errors++;
            $display("FAIL basic_byte%0d got %02h want %02h", i, (i < q.size()) ? q[i] : 8'hxx, exp[i]);
         end
      end
      checks++;
      if (fd_cnt != 1) begin errors++; $display("FAIL basic_flush_done got %0d pulses want 1", fd_cnt); end
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", bus.err); end
   endtask

   task automatic test_carry_run();
      logic [7:0] exp[$];
      exp = '{8'h11, 8'h00, 8'h00, 8'h05};
      apply_reset();
      send(9'h010, 1'b1);
      send(9'h0FF, 1'b1);
      send(9'h0FF, 1'b1);
      send(9'h105, 1'b1);
      idle(5, 1'b1);
      checks++;
      if (q.size() != 3) begin errors++; $display("FAIL carry_prefl_count got %0d want 3", q.size()); end
      do_flush();
      checks++;
      if (q.size() != exp.size()) begin errors++; $display("FAIL carry_count got %0d want %0d", q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (i >= q.size() || q[i] !== exp[i]) begin
            errors++;
            $display("FAIL carry_byte%0d got %02h want %02h", i, (i < q.size()) ? q[i] : 8'hxx, exp[i]);
         end
      end
      checks++;
      if (fd_cnt != 1) begin errors++; $display("FAIL carry_flush_done got %0d pulses want 1", fd_cnt); end
   endtask

   task automatic test_stall();
      logic [7:0] exp[$];
      exp = '{8'h20, 8'hFF, 8'h30};
      apply_reset();
      send(9'h020, 1'b1);
      send(9'h0FF, 1'b1);
      send(9'h030, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.out_ready = 1'b0;
         checks++;
         if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %b want 1", i, bus.out_valid); end
         checks++;
         if (bus.out_byte !== 8'h20) begin errors++; $display("FAIL stall_byte%0d got %02h want 20", i, bus.out_byte); end
         checks++;
         if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d got %b want 0", i, bus.in_ready); end
         @(negedge general_clk);
      end
      idle(4, 1'b1);
      do_flush();
      checks++;
      if (q.size() != exp.size()) begin errors++; $display("FAIL stall_count got %0d want %0d", q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (i >= q.size() || q[i] !== exp[i]) begin
            errors++;
            $display("FAIL stall_out%0d got %02h want %02h", i, (i < q.size()) ? q[i] : 8'hxx, exp[i]);
         end
      end
   endtask

   task automatic test_first_carry();
      apply_reset();
      send(9'h1AB, 1'b1);
      idle(3, 1'b1);
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL first_carry_err got %b want 1", bus.err); end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL first_carry_noout got %0d bytes want 0", q.size()); end
      do_flush();
      checks++;
      if (q.size() != 1 || q[0] !== 8'hAB) begin
         errors++;
         $display("FAIL first_carry_held got %0d bytes first=%02h want 1 byte AB", q.size(), (q.size() > 0) ? q[0] : 8'hxx);
      end
      idle(2, 1'b1);
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL first_carry_sticky got %b want 1", bus.err); end
      apply_reset();
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL first_carry_cleared got %b want 0", bus.err); end
   endtask

   task automatic test_wrap();
      apply_reset();
      send(9'h0FF, 1'b1);
      send(9'h100, 1'b1);
      idle(2, 1'b1);
      checks++;
      if (q.size() != 1 || q[0] !== 8'h00) begin
         errors++;
         $display("FAIL wrap_out got %0d bytes first=%02h want 1 byte 00", q.size(), (q.size() > 0) ? q[0] : 8'hxx);
      end
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL wrap_err got %b want 1", bus.err); end
   endtask

   task automatic test_reset_mid_run();
      apply_reset();
      send(9'h041, 1'b1);
      for (int i = 0; i < 4; i++) send(9'h0FF, 1'b1);
      send(9'h042, 1'b1);
      idle(2, 1'b1);
      checks++;
      if (q.size() != 2 || q[0] !== 8'h41 || q[1] !== 8'hFF) begin
         errors++;
         $display("FAIL midrun_prefix got %0d bytes want 41 FF", q.size());
      end
      reset = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrun_abort got out_valid=%b want 0", bus.out_valid); end
      @(negedge general_clk);
      reset = 1'b1;
      q.delete();
      fd_cnt = 0;
      idle(3, 1'b1);
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrun_in_ready got %b want 1", bus.in_ready); end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL midrun_quiet got %0d bytes want 0", q.size()); end
      do_flush();
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL midrun_flush_empty got %0d bytes want 0", q.size()); end
      checks++;
      if (fd_cnt != 1) begin errors++; $display("FAIL midrun_flush_done got %0d pulses want 1", fd_cnt); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      fd_cnt = 0;
      reset  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 9'h000;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge general_clk);
      test_reset();
      test_basic();
      test_carry_run();
      test_stall();
      test_first_carry();
      test_wrap();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
